// File: rtl/wptr_full.sv
// Write-side pointer and flag logic for an asynchronous FIFO.
// Keeps the binary/Gray write pointer. Uses the synchronized Gray read pointer
// to produce the registered full, almost-full and fill-level outputs.
// Also holds a sticky overflow flag for writes attempted while the FIFO is full.
module wptr_full #(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                i_wclk,
  input  logic                i_wrst,
  input  logic                i_winc,
  input  logic [ADDRSIZE:0]   i_rptr_sync,
  input  logic                i_ovf_clr,
  output logic                o_wen,
  output logic [ADDRSIZE-1:0] o_waddr,
  output logic [ADDRSIZE:0]   o_wptr,
  output logic                o_wfull,
  output logic                o_walmost_full,
  output logic [ADDRSIZE:0]   o_wlevel,
  output logic                o_overflow
);

  // Threshold sized to the level width so the compare is width-matched.
  localparam logic [ADDRSIZE:0] THRESH = (ADDRSIZE + 1)'(AFULL_THRESH);

  logic [ADDRSIZE:0] wbin_reg;
  logic [ADDRSIZE:0] wbin_next;
  logic [ADDRSIZE:0] wgray_next;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] full_cmp;
  logic [ADDRSIZE:0] level_next;
  logic              full_next;
  logic              almost_next;

  // The write strobe is qualified by the full flag.
  // It is also suppressed during reset, so that no RAM write escapes while the pointers clear.
  assign o_wen   = i_winc & ~o_wfull & ~i_wrst;
  assign o_waddr = wbin_reg[ADDRSIZE-1:0];

  assign wbin_next  = wbin_reg + {{ADDRSIZE{1'b0}}, o_wen};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  // Using a reduction per bit avoids a self-referencing chain on rbin.
  genvar gi;
  generate
    for (gi = 0; gi <= ADDRSIZE; gi++) begin : g_rbin
      assign rbin[gi] = ^i_rptr_sync[ADDRSIZE:gi];
    end
  endgenerate

  // Full when the next write pointer is exactly one lap ahead of the read pointer.
  // In Gray code, one lap ahead means the top two bits are inverted.
  assign full_cmp    = {~i_rptr_sync[ADDRSIZE:ADDRSIZE-1], i_rptr_sync[ADDRSIZE-2:0]};
  assign full_next   = (wgray_next == full_cmp);
  assign level_next  = wbin_next - rbin;
  assign almost_next = (level_next >= THRESH);

  // Pointer, level and flag registers, all cleared by reset.
  always_ff @(posedge i_wclk) begin
    if (i_wrst) begin
      wbin_reg       <= '0;
      o_wptr         <= '0;
      o_wfull        <= 1'b0;
      o_walmost_full <= 1'b0;
      o_wlevel       <= '0;
    end else begin
      wbin_reg       <= wbin_next;
      o_wptr         <= wgray_next;
      o_wfull        <= full_next;
      o_walmost_full <= almost_next;
      o_wlevel       <= level_next;
    end
  end

  // Sticky overflow flag. If a new overflow and a clear happen together, the overflow wins.
  always_ff @(posedge i_wclk) begin
    if (i_wrst) begin
      o_overflow <= 1'b0;
    end else if (i_winc && o_wfull) begin
      o_overflow <= 1'b1;
    end else if (i_ovf_clr) begin
      o_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full.
// The reference model counts writes and reads as plain integers.
// Every output is derived from those counts.
module tb_wptr_full;

  localparam int AS    = 4;
  localparam int TH    = 12;
  localparam int DEPTH = 16;
  localparam int PMOD  = 32;

  logic          clk = 1'b0;
  logic          wrst;
  logic          winc;
  logic          ovf_clr;
  logic [AS:0]   rptr_sync;
  logic          wen;
  logic [AS-1:0] waddr;
  logic [AS:0]   wptr;
  logic          wfull;
  logic          walmost_full;
  logic [AS:0]   wlevel;
  logic          overflow;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int wr_cnt     = 0;  // total accepted writes since reset
  int rd_cnt     = 0;  // read count the DUT has seen (registered view)
  int rd_in      = 0;  // read count currently driven on i_rptr_sync
  bit m_ovf      = 1'b0;
  bit check_en   = 1'b0;

  always #5 clk = ~clk;

  wptr_full #(.ADDRSIZE(AS), .AFULL_THRESH(TH)) dut (
    .i_wclk         (clk),
    .i_wrst         (wrst),
    .i_winc         (winc),
    .i_rptr_sync    (rptr_sync),
    .i_ovf_clr      (ovf_clr),
    .o_wen          (wen),
    .o_waddr        (waddr),
    .o_wptr         (wptr),
    .o_wfull        (wfull),
    .o_walmost_full (walmost_full),
    .o_wlevel       (wlevel),
    .o_overflow     (overflow)
  );

  function automatic logic [AS:0] gray(int v);
    logic [AS:0] b;
    b = (AS + 1)'(v % PMOD);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic drive(bit w, bit clr, bit rst, int rd);
    winc      = w;
    ovf_clr   = clr;
    wrst      = rst;
    rd_in     = rd;
    rptr_sync = gray(rd);
  endtask

  // One clock. The model advances on the edge, using the inputs that were held across it.
  task automatic tick();
    bit m_full;
    bit acc;
    @(posedge clk);
    cyc++;
    m_full = ((wr_cnt - rd_cnt) == DEPTH);
    acc    = winc && !m_full && !wrst;
    if (wrst) begin
      wr_cnt = 0;
      rd_cnt = 0;
      m_ovf  = 1'b0;
    end else begin
      if (winc && m_full) m_ovf = 1'b1;
      else if (ovf_clr)   m_ovf = 1'b0;
      if (acc) wr_cnt++;
      rd_cnt = rd_in;
    end
    #1;
    $display("cyc %0d rst=%0b winc=%0b clr=%0b rd=%0d -> writes=%0d level=%0d ovf=%0b",
             cyc, wrst, winc, ovf_clr, rd_in, wr_cnt, wr_cnt - rd_cnt, m_ovf);
  endtask

  // Every-cycle comparison against the count-based model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      int lvl;
      lvl = wr_cnt - rd_cnt;
      chk("wlevel",   int'(wlevel),       lvl);
      chk("wfull",    int'(wfull),        int'(lvl == DEPTH));
      chk("walmost",  int'(walmost_full), int'(lvl >= TH));
      chk("wptr",     int'(wptr),         int'(gray(wr_cnt)));
      chk("waddr",    int'(waddr),        wr_cnt % DEPTH);
      chk("overflow", int'(overflow),     int'(m_ovf));
      chk("wen",      int'(wen),          int'(winc && (lvl != DEPTH) && !wrst));
    end
  end

  task automatic do_reset();
    drive(0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0);
  endtask

  initial begin
    drive(0, 0, 1, 0);
    tick();
    tick();
    check_en = 1'b1;
    chk("lit_reset_level", int'(wlevel), 0);
    chk("lit_reset_wptr",  int'(wptr),   0);

    // Fill from empty: 16 consecutive writes.
    drive(0, 0, 0, 0);
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1, 0, 0, 0);
      tick();
      if (i == 3)  chk("lit_gray3", int'(wptr), 5'b00010);
      if (i == 11) chk("lit_almost11", int'(walmost_full), 0);
      if (i == 12) chk("lit_almost12", int'(walmost_full), 1);
      if (i == 15) chk("lit_full15", int'(wfull), 0);
    end
    chk("lit_fill_full",  int'(wfull),  1);
    chk("lit_fill_level", int'(wlevel), 16);
    chk("lit_fill_wptr",  int'(wptr),   5'b11000);

    // Write attempts while full.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0);
      #1 chk("lit_full_wen", int'(wen), 0);
      tick();
    end
    chk("lit_ovf_set",   int'(overflow), 1);
    chk("lit_ovf_wptr",  int'(wptr),     5'b11000);
    drive(1, 1, 0, 0);                       // set and clear together
    tick();
    chk("lit_ovf_prio",  int'(overflow), 1);
    drive(0, 1, 0, 0);
    tick();
    chk("lit_ovf_clr",   int'(overflow), 0);

    // Release: the read pointer advances by one.
    drive(0, 0, 0, 1);
    tick();
    chk("lit_rel_full",   int'(wfull),        0);
    chk("lit_rel_level",  int'(wlevel),       15);
    chk("lit_rel_almost", int'(walmost_full), 1);

    // Wrap: steady level of 4 across more than one pointer lap.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      drive(1, 0, 0, rd_in + 1);
      tick();
    end
    chk("lit_wrap_level", int'(wlevel), 4);
    chk("lit_wrap_wptr",  int'(wptr),   5'b01010);

    // Reset in the middle of a burst, at level 9.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    drive(1, 1, 1, 0);
    #1 chk("lit_rst_wen", int'(wen), 0);
    tick();
    chk("lit_rst_level", int'(wlevel), 0);
    chk("lit_rst_wptr",  int'(wptr),   0);
    chk("lit_rst_waddr", int'(waddr),  0);

    // Simultaneous write and read advance at level 11.
    drive(0, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    drive(1, 0, 0, 1);
    tick();
    chk("lit_sim_level",  int'(wlevel),       11);
    chk("lit_sim_almost", int'(walmost_full), 0);

    // Randomized traffic with a legal reader (never overtakes the writer).
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      bit w;
      bit clr;
      bit rst;
      int rd;
      w   = ($urandom_range(0, 99) < 65);
      clr = ($urandom_range(0, 99) < 8);
      rst = ($urandom_range(0, 199) == 0);
      rd  = rd_in;
      if (($urandom_range(0, 99) < 45) && (rd < wr_cnt)) rd++;
      if (rst) rd = 0;
      drive(w, clr, rst, rd);
      tick();
    end

    drive(0, 0, 0, rd_in);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wptr_full.md
WPTR_FULL -- requirements
Module: wptr_full

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4, address width; FIFO depth = 2^ADDRSIZE.
REQ-002 SHALL have parameter AFULL_THRESH, default 12, fill level at or above which o_walmost_full asserts; legal range 1..2^ADDRSIZE.
REQ-003 SHALL have port i_wclk, input, 1, write-domain clock; the only clock.
REQ-004 SHALL have port i_wrst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port i_winc, input, 1, write request from producer.
REQ-006 SHALL have port i_rptr_sync, input, ADDRSIZE+1, Gray-coded read pointer already two-flop synchronized into i_wclk.
REQ-007 SHALL have port i_ovf_clr, input, 1, clears sticky overflow flag.
REQ-008 SHALL have port o_wen, output, 1, qualified write strobe to RAM = i_winc AND NOT o_wfull (combinational).
REQ-009 SHALL have port o_waddr, output, ADDRSIZE, RAM write address = wbin[ADDRSIZE-1:0].
REQ-010 SHALL have port o_wptr, output, ADDRSIZE+1, registered Gray write pointer sent to read-domain synchronizer.
REQ-011 SHALL have port o_wfull, output, 1, registered full flag.
REQ-012 SHALL have port o_walmost_full, output, 1, registered almost-full flag.
REQ-013 SHALL have port o_wlevel, output, ADDRSIZE+1, registered write-side fill level, range 0..2^ADDRSIZE.
REQ-014 SHALL have port o_overflow, output, 1, sticky: write attempted while full.

Function
REQ-015 SHALL hold internal binary pointer wbin, ADDRSIZE+1 bits; wbin_next = wbin + o_wen, modulo 2^(ADDRSIZE+1) (natural wrap, no saturation).
REQ-016 SHALL compute wgray_next = (wbin_next >> 1) XOR wbin_next; o_wptr <= wgray_next each cycle; exactly one bit of o_wptr changes per accepted write.
REQ-017 SHALL register full: o_wfull <= (wgray_next == {~i_rptr_sync[ADDRSIZE:ADDRSIZE-1], i_rptr_sync[ADDRSIZE-2:0]}).
REQ-018 SHALL convert i_rptr_sync Gray to binary rbin (prefix XOR from MSB) combinationally.
REQ-019 SHALL compute level_next = wbin_next - rbin, ADDRSIZE+1 bits modulo; o_wlevel <= level_next.
REQ-020 SHALL register o_walmost_full <= (level_next >= AFULL_THRESH).
REQ-021 SHALL, while o_wfull=1, ignore i_winc: wbin, o_waddr, o_wptr unchanged, o_wen=0.
REQ-022 SHALL set o_overflow <= 1 on any cycle with i_winc=1 and o_wfull=1; o_overflow holds until i_ovf_clr=1.
REQ-023 SHALL give set priority over clear: i_winc=1, o_wfull=1, i_ovf_clr=1 in same cycle leaves o_overflow=1.
REQ-024 SHALL deassert o_wfull the cycle after i_rptr_sync advances past the full comparison; latency from read to full release is set by the upstream synchronizer only (pessimistic, never optimistic).
REQ-025 SHALL treat simultaneous write and read-pointer advance correctly: o_wlevel unchanged, o_wfull evaluated against new values of both pointers.
REQ-026 SHALL make o_wlevel, o_wfull, o_walmost_full reflect the write accepted in cycle N starting cycle N+1.

Reset
REQ-027 SHALL, on i_wclk rising edge with i_wrst=1, set wbin=0, o_wptr=0, o_wfull=0, o_walmost_full=0, o_wlevel=0, o_overflow=0; o_waddr=0.
REQ-028 SHALL give i_wrst priority over all inputs, including mid-burst writes and i_ovf_clr; o_wen SHALL be 0 during reset.
REQ-029 SHALL require i_rptr_sync=0 after reset (read side reset together); no other state survives reset.

Verification (ADDRSIZE=4, AFULL_THRESH=12)
REQ-030 SHALL cover fill: reset, i_rptr_sync=0, i_winc=1 for 16 cycles -> o_waddr 0..15, o_wptr Gray sequence 00000,00001,00011,...; o_walmost_full=1 after 12th write, o_wfull=1 after 16th, o_wlevel=16.
REQ-031 SHALL cover write-when-full: after fill, i_winc=1 for 3 cycles -> o_wen=0, o_wptr=11000 unchanged, o_overflow=1; pulse i_ovf_clr -> o_overflow=0 next cycle.
REQ-032 SHALL cover release: full, then i_rptr_sync=00001 -> next cycle o_wfull=0, o_wlevel=15, o_walmost_full=1.
REQ-033 SHALL cover wrap: 40 writes with i_rptr_sync tracking Gray(wbin-4) -> o_wlevel=4 steady, wbin wraps 31->0, o_wfull never asserts.
REQ-034 SHALL cover reset mid-operation: i_wrst=1 at level 9 with i_winc=1 -> next cycle all outputs 0, no write strobe.
REQ-035 SHALL cover simultaneous write and read advance at level 11 -> o_wlevel stays 11, o_walmost_full stays 0.
